seq_mult_n: RTL and testbench

- Parametrised sequential shift-add multiplier with its own controller FSM and a start/done handshake.
- Replaces the external-controller Load/Shift/Add datapath pairing: one block accepts two WIDTH-bit operands and returns a 2*WIDTH-bit product after a fixed WIDTH-cycle iteration.
- Used wherever an area-cheap multiply with deterministic latency is needed. Carry out of the partial-sum add is fully preserved at every width.

---
 rtl/seq_mult_n.sv | 93 +++++++++
 tb/tb_seq_mult_n.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_n.sv
// Sequential shift-add multiplier with its own start/done controller: one WIDTH-cycle add+shift loop per product.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and product; unsigned otherwise.
module seq_mult_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     word1,
  input  logic [WIDTH-1:0]     word2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplr;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 last;

  assign last = (cnt == CNT_W'(1));

  // The WIDTH+1-bit partial sum lands in acc[2W-1:W-1]; its top bit is the carry (or sign).
`ifdef SEQ_MULT_SIGNED_EN
  logic signed [WIDTH:0] hi_s;
  logic signed [WIDTH:0] mc_s;
  logic signed [WIDTH:0] sum_s;

  always_comb begin
    hi_s  = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
    mc_s  = {mcand[WIDTH-1], mcand};
    sum_s = hi_s;
    if (mplr[0]) begin
      // The multiplier's top bit carries weight -2^(W-1), so it subtracts.
      sum_s = last ? (hi_s - mc_s) : (hi_s + mc_s);
    end
    acc_next = {sum_s, acc[WIDTH-1:1]};
  end
`else
  logic [WIDTH:0] sum_u;

  always_comb begin
    sum_u    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mcand} : '0);
    acc_next = {sum_u, acc[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= word1;
            mplr  <= word2;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          mplr <= mplr >> 1;
          cnt  <= cnt - CNT_W'(1);
          if (last) begin
            product <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_n.sv
// Scoreboard bench for seq_mult_n (WIDTH=8); follows SEQ_MULT_SIGNED_EN for the operand interpretation.
module tb_seq_mult_n;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   word1 = '0;
  logic [W-1:0]   word2 = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  logic prev_done = 1'b0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_mult_n #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .word1(word1), .word2(word2),
    .busy(busy), .done(done), .product(product)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
  endfunction

  // Scoreboard side: every done pulse retires the oldest expected product.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      done_seen++;
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
      else chk("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
    end
    prev_done = done;
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] e);
    start = 1'b1;
    word1 = a;
    word2 = b;
    exp_q.push_back(e);
  endtask

  // Follows one accepted operation to its done pulse; optionally pokes start at RUN cycles 3 and 5.
  task automatic wait_done(input bit glitch);
    int edges;
    int busy_n;
    @(negedge clk);
    edges = 0;
    busy_n = 0;
    chk("done_drop", {31'd0, done}, 32'd0);
    while (done !== 1'b1 && edges < 4 * W) begin
      if (busy === 1'b1) busy_n++;
      start = glitch && (edges == 2 || edges == 4);
      word1 = W'($urandom);
      word2 = W'($urandom);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    chk("latency", edges, W);
    chk("busy_cycles", busy_n, W);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] e);
    start_op(a, b, e);
    wait_done(1'b0);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'h0000);

    d0 = done_seen;
    repeat (20) @(negedge clk);
    chk("idle_no_done", done_seen - d0, 0);

    run(8'd13, 8'd11, 16'h008F);
`ifdef SEQ_MULT_SIGNED_EN
    run(8'hFF, 8'hFF, 16'h0001);
    run(8'h80, 8'h80, 16'h4000);
    run(8'h07, 8'hFD, 16'hFFEB);
    run(8'h80, 8'h7F, 16'hC080);
    run(8'h00, 8'hC8, 16'h0000);
`else
    run(8'd255, 8'd255, 16'hFE01);
    run(8'd0, 8'd200, 16'h0000);
    run(8'd1, 8'd255, 16'h00FF);
`endif

    // Ignored starts during RUN, then a start accepted in the done cycle.
    start_op(8'd100, 8'd2, 16'h00C8);
    wait_done(1'b1);
    start_op(8'd6, 8'd7, 16'h002A);
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    chk("product_hold", {16'd0, product}, 32'h002A);

    // Abort mid-RUN with an asynchronous reset between clock edges.
    start_op(8'd200, 8'd3, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'h0000);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    d0 = done_seen;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);

`ifdef SEQ_MULT_SIGNED_EN
    run(8'd200, 8'd3, 16'hFF58);
`else
    run(8'd200, 8'd3, 16'h0258);
`endif

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run(ra, rb, model(ra, rb));
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
